// File: rtl/xor_serial_thirty_two_pkg.sv
// Shared definitions for the nibble-serial XOR engine: FSM states and slice width.
package xor_serial_thirty_two_pkg;

  // Width of one serial step in bits.
  localparam int NIBBLE_W = 4;

  // Operation sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xor_fourbit.sv
// Combinational 4-bit XOR slice used once per serial step.
module xor_fourbit
  import xor_serial_thirty_two_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic [NIBBLE_W-1:0] y
);

  // Bitwise XOR of the two nibbles.
  assign y = a ^ b;

endmodule

// File: rtl/xor_serial_thirty_two.sv
// Nibble-serial XOR: latches two operands on start, then writes one
// 4-bit slice of the result per clock, LSB nibble first, and pulses done.
module xor_serial_thirty_two
  import xor_serial_thirty_two_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Output
);

  // A single-nibble configuration still needs a one-bit counter.
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t              state;
  state_t              stateNext;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    opA;
  logic [WIDTH-1:0]    opB;
  logic [NIBBLE_W-1:0] sliceA;
  logic [NIBBLE_W-1:0] sliceB;
  logic [NIBBLE_W-1:0] sliceRes;
  logic                accept;

  // start only counts outside RUN; in RUN it is simply ignored.
  assign accept = start && (state != RUN);

  // Select the operand nibbles addressed by the step counter.
  always_comb begin
    sliceA = opA[int'(cnt)*NIBBLE_W +: NIBBLE_W];
    sliceB = opB[int'(cnt)*NIBBLE_W +: NIBBLE_W];
  end

  xor_fourbit u_slice (
    .a (sliceA),
    .b (sliceB),
    .y (sliceRes)
  );

  // State register; reset lands in IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: DONE either restarts (start high) or falls back to IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (cnt == LAST) stateNext = DONE;
      DONE:    stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: capture operands and clear the result on accept, then fill one nibble per RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      opA    <= '0;
      opB    <= '0;
      Output <= '0;
    end else if (accept) begin
      cnt    <= '0;
      opA    <= input1;
      opB    <= input2;
      Output <= '0;
    end else if (state == RUN) begin
      Output[int'(cnt)*NIBBLE_W +: NIBBLE_W] <= sliceRes;
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Status flags decode straight from state so reset clears them without a clock.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_xor_serial_thirty_two.sv
// Self-checking bench for xor_serial_thirty_two against an arithmetic model.
module tb_xor_serial_thirty_two;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Output;

  int checks = 0;
  int errors = 0;

  xor_serial_thirty_two #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .input1 (input1),
    .input2 (input2),
    .busy   (busy),
    .done   (done),
    .Output (Output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected result after k written nibbles: low 4k bits of a^b, rest zero.
  function automatic logic [WIDTH-1:0] partial(input logic [WIDTH-1:0] x, input int k);
    logic [63:0] mask;
    if (k >= NIB) return x;
    mask = (64'd1 << (4 * k)) - 64'd1;
    return x & mask[WIDTH-1:0];
  endfunction

  // Present operands with start for one edge; returns at the negedge after acceptance.
  task automatic launch_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    input1 = a;
    input2 = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic test_reset_then_op();
    logic [WIDTH-1:0] a, b, x;
    a = 32'hFFFF0000;
    b = 32'h0F0F0F0F;
    x = a ^ b;
    rst_n = 1'b0;
    start = 1'b1;
    input1 = a;
    input2 = b;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Output !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state busy=%b done=%b Output=%h required 0 0 0", busy, done, Output);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    input1 = $urandom;
    input2 = $urandom;
    for (int k = 0; k < NIB; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || Output !== partial(x, k)) begin
        errors++;
        $display("[TB] FAIL run_cycle%0d busy=%b done=%b Output=%h required 1 0 %h", k, busy, done, Output, partial(x, k));
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || Output !== 32'hF0F00F0F) begin
      errors++;
      $display("[TB] FAIL first_done done=%b busy=%b Output=%h required 1 0 f0f00f0f", done, busy, Output);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || Output !== 32'hF0F00F0F) begin
      errors++;
      $display("[TB] FAIL idle_hold done=%b busy=%b Output=%h required 0 0 f0f00f0f", done, busy, Output);
    end
  endtask

  task automatic test_partial();
    launch_op(32'h12345678, 32'h00000000);
    repeat (3) @(negedge clk);
    checks++;
    if (Output !== 32'h00000678 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL partial_3 Output=%h busy=%b required 00000678 1", Output, busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || Output !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL partial_final done=%b Output=%h required 1 12345678", done, Output);
    end
  endtask

  task automatic test_ignored_start();
    logic [WIDTH-1:0] a, b, got;
    int doneCount, doneAt;
    a = $urandom;
    b = $urandom;
    launch_op(a, b);
    repeat (3) @(negedge clk);
    input1 = ~a;
    input2 = b ^ 32'h5555AAAA;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    doneCount = 0;
    doneAt = -1;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      if (done === 1'b1) begin
        doneCount++;
        doneAt = i;
        got = Output;
      end
      @(negedge clk);
    end
    checks++;
    if (doneCount != 1 || doneAt != 4) begin
      errors++;
      $display("[TB] FAIL ignored_start_pulses count=%0d at=%0d required 1 at 4", doneCount, doneAt);
    end
    checks++;
    if (got !== (a ^ b)) begin
      errors++;
      $display("[TB] FAIL ignored_start_value Output=%h required %h", got, a ^ b);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    a = 32'h12345678;
    b = $urandom | 32'h1;
    launch_op(a, b);
    repeat (7) @(negedge clk);
    input1 = 32'hAAAAAAAA;
    input2 = 32'hAAAAAAAA;
    start  = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || Output !== (a ^ b)) begin
      errors++;
      $display("[TB] FAIL b2b_first_done done=%b Output=%h required 1 %h", done, Output, a ^ b);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || Output !== '0) begin
      errors++;
      $display("[TB] FAIL b2b_restart busy=%b done=%b Output=%h required 1 0 0", busy, done, Output);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || Output !== 32'h00000000) begin
      errors++;
      $display("[TB] FAIL b2b_second_done done=%b Output=%h required 1 0", done, Output);
    end
  endtask

  task automatic test_reset_mid_op();
    int doneCount;
    launch_op(32'hDEADBEEF, 32'h01234567);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Output !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset busy=%b done=%b Output=%h required 0 0 0", busy, done, Output);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) doneCount++;
    end
    checks++;
    if (doneCount != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done active_cycles=%0d required 0", doneCount);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    int waitCycles;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = $urandom;
      b = $urandom;
      launch_op(a, b);
      input1 = $urandom;
      input2 = $urandom;
      waitCycles = 0;
      while (done !== 1'b1 && waitCycles < 20) begin
        @(negedge clk);
        waitCycles++;
      end
      checks++;
      if (done !== 1'b1 || waitCycles != NIB || Output !== (a ^ b)) begin
        errors++;
        $display("[TB] FAIL random_op%0d done=%b latency=%0d Output=%h required 1 %0d %h",
                 n, done, waitCycles, Output, NIB, a ^ b);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    input1 = '0;
    input2 = '0;
    test_reset_then_op();
    test_partial();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
